// File: rtl/m_serial_pair_tx_pkg.sv
// Shared types and helpers for the serial operand-pair transmitter.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package m_serial_pair_tx_pkg;

  // Default operand width and the widest width the parity helper handles.
  localparam int D_N_DEF = 32;
  localparam int P_MAX_W = 64;

  // Transmitter FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // XOR-reduce of (a + b) truncated to n bits; the carry out of bit n-1 and
  // any bits above it are ignored. Operands are zero-extended by the caller.
  function automatic logic f_sum_parity(input logic [P_MAX_W-1:0] a_v,
                                        input logic [P_MAX_W-1:0] b_v,
                                        input int               n);
    logic [P_MAX_W-1:0] sum_v;
    logic               p;
    sum_v = a_v + b_v;
    p     = 1'b0;
    for (int i = 0; i < P_MAX_W; i++) begin
      if (i < n) begin
        p = p ^ sum_v[i];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/m_serial_pair_tx_piso.sv
// Parallel-in serial-out register: load a word, shift right with zero fill.
// Latency: loaded word's bit 0 is on w_ser the cycle after w_load.
// Backpressure: none; load wins over shift when both are asserted.
module m_piso
  import m_serial_pair_tx_pkg::*;
#(
  parameter int D_N = D_N_DEF
) (
  input  logic           w_clk,
  input  logic           w_rst_n,
  input  logic           w_load,
  input  logic           w_shift,
  input  logic [D_N-1:0] w_din,
  output logic           w_ser
);

  logic [D_N-1:0] sr_q;

  // Shift register: parallel load, otherwise shift toward bit 0.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      sr_q <= '0;
    end else if (w_load) begin
      sr_q <= w_din;
    end else if (w_shift) begin
      sr_q <= {1'b0, sr_q[D_N-1:1]};
    end
  end

  assign w_ser = sr_q[0];

endmodule

// File: rtl/m_serial_pair_tx.sv
// Bit-serial transmitter of an operand pair, LSB first, plus parity of their sum.
// Latency: accept at edge T -> bit k in cycle T+1+k, w_done in T+D_N+1.
// Backpressure: w_ready only in IDLE; one pair per D_N+2 cycles at best.
module m_serial_pair_tx
  import m_serial_pair_tx_pkg::*;
#(
  parameter int D_N = D_N_DEF
) (
  input  logic           w_clk,
  input  logic           w_rst_n,
  input  logic           w_valid,
  output logic           w_ready,
  input  logic [D_N-1:0] w_a_in,
  input  logic [D_N-1:0] w_b_in,
  output logic           w_a,
  output logic           w_b,
  output logic           w_busy,
  output logic           w_last,
  output logic           w_done,
  output logic           w_par
);

  // Counter only needs to reach D_N-1; the exit happens there, so no wrap.
  localparam int               CNT_W    = (D_N > 1) ? $clog2(D_N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(D_N - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             par_q;
  logic             accept;
  logic             shift_en;
  logic             a_ser;
  logic             b_ser;

  assign accept   = w_valid && w_ready;
  assign shift_en = (state_q == ST_SHIFT);

  m_piso #(.D_N(D_N)) u_piso_a (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .w_load  (accept),
    .w_shift (shift_en),
    .w_din   (w_a_in),
    .w_ser   (a_ser)
  );

  m_piso #(.D_N(D_N)) u_piso_b (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .w_load  (accept),
    .w_shift (shift_en),
    .w_din   (w_b_in),
    .w_ser   (b_ser)
  );

  // FSM state register.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and outputs, all decoded from registered state; serial lines
  // are forced low outside SHIFT so a stale shift-register LSB never leaks.
  always_comb begin
    state_d = state_q;
    w_ready = 1'b0;
    w_busy  = 1'b0;
    w_last  = 1'b0;
    w_done  = 1'b0;
    w_a     = 1'b0;
    w_b     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (w_valid) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_busy = 1'b1;
        w_a    = a_ser;
        w_b    = b_ser;
        if (cnt_q == CNT_LAST) begin
          w_last  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        w_done  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bit counter: cleared on accept, advances once per serial bit.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (shift_en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Sum parity captured at accept and held until the next accept.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= f_sum_parity(P_MAX_W'(w_a_in), P_MAX_W'(w_b_in), D_N);
    end
  end

  assign w_par = par_q;

endmodule
